// File: rtl/axil2hpi_slv_adp_pkg.sv
// Shared constants and helpers for the AXI4-lite to HPI slave adapter.
package axil2hpi_slv_adp_pkg;

   localparam logic [1:0]  AXI_RESP_OKAY    = 2'b00;
   localparam logic [1:0]  AXI_RESP_SLVERR  = 2'b10;
   localparam logic [31:0] RD_TMOUT_PATTERN = 32'hDEADBEEF;

   localparam int unsigned TMOUT_CNT_W = 16;

   typedef logic [TMOUT_CNT_W-1:0] tmout_cnt_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic tmout_cnt_t sat_inc(input tmout_cnt_t v);
      return (v == '1) ? v : v + tmout_cnt_t'(1);
   endfunction

endpackage

// File: rtl/axil2hpi_slv_adp.sv
// AXI4-lite slave that turns single transactions into one-cycle local
// read/write strobes, with a configurable read-data timeout.
module axil2hpi_slv_adp
   import axil2hpi_slv_adp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH    = 32,
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned DATA_BYTE_NUM = DATA_WIDTH / 8
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     awvalid,
   output logic                     awready,
   input  logic [ADDR_WIDTH-1:0]    awaddr,
   input  logic                     wvalid,
   output logic                     wready,
   input  logic [DATA_WIDTH-1:0]    wdata,
   input  logic [DATA_BYTE_NUM-1:0] wstrb,
   output logic                     bvalid,
   input  logic                     bready,
   output logic [1:0]               bresp,
   input  logic                     arvalid,
   output logic                     arready,
   input  logic [ADDR_WIDTH-1:0]    araddr,
   output logic                     rvalid,
   input  logic                     rready,
   output logic [DATA_WIDTH-1:0]    rdata,
   output logic [1:0]               rresp,
   output logic                     cpu_wr,
   output logic [ADDR_WIDTH-1:0]    cpu_wr_addr,
   output logic [DATA_BYTE_NUM-1:0] cpu_wr_strb,
   output logic [DATA_WIDTH-1:0]    cpu_data_out,
   output logic                     cpu_rd,
   output logic [ADDR_WIDTH-1:0]    cpu_rd_addr,
   input  logic                     cpu_data_in_vld,
   input  logic [DATA_WIDTH-1:0]    cpu_data_in,
   input  logic [15:0]              rd_tmout_cfg,
   output logic                     rd_tmout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_WAIT_W,
      S_WR_WAIT_AW,
      S_WR_RESP,
      S_RD_WAIT,
      S_RD_RESP
   } state_t;

   state_t                   state, state_nxt;
   logic [1:0]               rdy_dly;
   logic                     ready_en;
   tmout_cnt_t               rd_cnt, rd_cnt_nxt;
   logic                     aw_hs, w_hs, ar_hs;
   logic                     rd_data_hit, rd_tmout_hit;

   logic                     bvalid_nxt, rvalid_nxt, cpu_wr_nxt, cpu_rd_nxt;
   logic [DATA_WIDTH-1:0]    rdata_nxt, cpu_data_out_nxt;
   logic [1:0]               rresp_nxt;
   logic [ADDR_WIDTH-1:0]    cpu_wr_addr_nxt, cpu_rd_addr_nxt;
   logic [DATA_BYTE_NUM-1:0] cpu_wr_strb_nxt;

   // Ready signals stay low for a full cycle after reset release.
   assign ready_en = rdy_dly[1];
   assign awready  = ready_en && (state == S_IDLE || state == S_WR_WAIT_AW);
   assign wready   = ready_en && (state == S_IDLE || state == S_WR_WAIT_W);
   assign arready  = ready_en && (state == S_IDLE) && !awvalid && !wvalid;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;

   // Local data wins over a timeout landing in the same cycle.
   assign rd_data_hit  = (state == S_RD_WAIT) && cpu_data_in_vld;
   assign rd_tmout_hit = (state == S_RD_WAIT) && !cpu_data_in_vld &&
                         (rd_tmout_cfg != '0) && (rd_cnt == rd_tmout_cfg);
   assign rd_tmout_err = rd_tmout_hit;

   assign bresp = AXI_RESP_OKAY;

   // Next-state and next-output decode.
   always_comb begin
      state_nxt        = state;
      rd_cnt_nxt       = rd_cnt;
      bvalid_nxt       = bvalid;
      rvalid_nxt       = rvalid;
      rdata_nxt        = rdata;
      rresp_nxt        = rresp;
      cpu_wr_nxt       = 1'b0;
      cpu_rd_nxt       = 1'b0;
      cpu_wr_addr_nxt  = cpu_wr_addr;
      cpu_wr_strb_nxt  = cpu_wr_strb;
      cpu_data_out_nxt = cpu_data_out;
      cpu_rd_addr_nxt  = cpu_rd_addr;

      case (state)
         S_IDLE: begin
            if (aw_hs) cpu_wr_addr_nxt = awaddr;
            if (w_hs) begin
               cpu_data_out_nxt = wdata;
               cpu_wr_strb_nxt  = wstrb;
            end
            if (aw_hs && w_hs) begin
               state_nxt  = S_WR_RESP;
               cpu_wr_nxt = 1'b1;
               bvalid_nxt = 1'b1;
            end else if (aw_hs) begin
               state_nxt = S_WR_WAIT_W;
            end else if (w_hs) begin
               state_nxt = S_WR_WAIT_AW;
            end else if (ar_hs) begin
               state_nxt       = S_RD_WAIT;
               cpu_rd_nxt      = 1'b1;
               cpu_rd_addr_nxt = araddr;
               rd_cnt_nxt      = '0;
            end
         end
         S_WR_WAIT_W: begin
            if (w_hs) begin
               cpu_data_out_nxt = wdata;
               cpu_wr_strb_nxt  = wstrb;
               state_nxt        = S_WR_RESP;
               cpu_wr_nxt       = 1'b1;
               bvalid_nxt       = 1'b1;
            end
         end
         S_WR_WAIT_AW: begin
            if (aw_hs) begin
               cpu_wr_addr_nxt = awaddr;
               state_nxt       = S_WR_RESP;
               cpu_wr_nxt      = 1'b1;
               bvalid_nxt      = 1'b1;
            end
         end
         S_WR_RESP: begin
            if (bready) begin
               bvalid_nxt = 1'b0;
               state_nxt  = S_IDLE;
            end
         end
         S_RD_WAIT: begin
            rd_cnt_nxt = sat_inc(rd_cnt);
            if (rd_data_hit) begin
               rdata_nxt  = cpu_data_in;
               rresp_nxt  = AXI_RESP_OKAY;
               rvalid_nxt = 1'b1;
               state_nxt  = S_RD_RESP;
            end else if (rd_tmout_hit) begin
               rdata_nxt  = DATA_WIDTH'(RD_TMOUT_PATTERN);
               rresp_nxt  = AXI_RESP_SLVERR;
               rvalid_nxt = 1'b1;
               state_nxt  = S_RD_RESP;
            end
         end
         S_RD_RESP: begin
            if (rready) begin
               rvalid_nxt = 1'b0;
               state_nxt  = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any transaction in flight.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state        <= S_IDLE;
         rdy_dly      <= '0;
         rd_cnt       <= '0;
         bvalid       <= 1'b0;
         rvalid       <= 1'b0;
         rdata        <= '0;
         rresp        <= '0;
         cpu_wr       <= 1'b0;
         cpu_rd       <= 1'b0;
         cpu_wr_addr  <= '0;
         cpu_wr_strb  <= '0;
         cpu_data_out <= '0;
         cpu_rd_addr  <= '0;
      end else begin
         state        <= state_nxt;
         rdy_dly      <= {rdy_dly[0], 1'b1};
         rd_cnt       <= rd_cnt_nxt;
         bvalid       <= bvalid_nxt;
         rvalid       <= rvalid_nxt;
         rdata        <= rdata_nxt;
         rresp        <= rresp_nxt;
         cpu_wr       <= cpu_wr_nxt;
         cpu_rd       <= cpu_rd_nxt;
         cpu_wr_addr  <= cpu_wr_addr_nxt;
         cpu_wr_strb  <= cpu_wr_strb_nxt;
         cpu_data_out <= cpu_data_out_nxt;
         cpu_rd_addr  <= cpu_rd_addr_nxt;
      end
   end

endmodule

// File: tb/tb_axil2hpi_slv_adp.sv
// Self-checking bench for axil2hpi_slv_adp: directed table, hand-written
// corner sequences and random transactions against a timing model.
module tb_axil2hpi_slv_adp;

   localparam int BOUND = 120;

   logic        aclk = 1'b0;
   logic        areset = 1'b0;
   logic        awvalid = 1'b0, awready;
   logic [31:0] awaddr = '0;
   logic        wvalid = 1'b0, wready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        bvalid, bready = 1'b0;
   logic [1:0]  bresp;
   logic        arvalid = 1'b0, arready;
   logic [31:0] araddr = '0;
   logic        rvalid, rready = 1'b0;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        cpu_wr;
   logic [31:0] cpu_wr_addr;
   logic [3:0]  cpu_wr_strb;
   logic [31:0] cpu_data_out;
   logic        cpu_rd;
   logic [31:0] cpu_rd_addr;
   logic        cpu_data_in_vld = 1'b0;
   logic [31:0] cpu_data_in = '0;
   logic [15:0] rd_tmout_cfg = '0;
   logic        rd_tmout_err;

   int errors = 0;
   int checks = 0;

   axil2hpi_slv_adp dut (
      .aclk(aclk), .areset(areset),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .arvalid(arvalid), .arready(arready), .araddr(araddr),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_strb(cpu_wr_strb),
      .cpu_data_out(cpu_data_out), .cpu_rd(cpu_rd), .cpu_rd_addr(cpu_rd_addr),
      .cpu_data_in_vld(cpu_data_in_vld), .cpu_data_in(cpu_data_in),
      .rd_tmout_cfg(rd_tmout_cfg), .rd_tmout_err(rd_tmout_err)
   );

   always #5 aclk = ~aclk;

   // Transaction record. Write: d0=AW delay, d1=W delay, d2=bready delay.
   // Read: d0=vld cycle (-1 none), d1=rready delay, d2=cycle cfg_b applies.
   typedef struct {
      logic        is_rd;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      int          d0, d1, d2;
      logic [15:0] cfg_a, cfg_b;
      int          late;
      int          e_cpu, e_resp, e_tmo;
      logic [31:0] e_rdata;
      logic [1:0]  e_rresp;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic vec_t mk_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                  input int awd, input int wd, input int bd, input int ec, input int er);
      vec_t v;
      v.is_rd = 1'b0; v.addr = a; v.data = d; v.strb = s;
      v.d0 = awd; v.d1 = wd; v.d2 = bd; v.cfg_a = '0; v.cfg_b = '0; v.late = -1;
      v.e_cpu = ec; v.e_resp = er; v.e_tmo = -1; v.e_rdata = '0; v.e_rresp = 2'b00;
      return v;
   endfunction

   function automatic vec_t mk_rd(input logic [31:0] a, input logic [31:0] d, input int vd, input int lt,
                                  input int rd, input logic [15:0] ca, input logic [15:0] cb, input int sw,
                                  input int ec, input int er, input int et, input logic [31:0] edat,
                                  input logic [1:0] eresp);
      vec_t v;
      v.is_rd = 1'b1; v.addr = a; v.data = d; v.strb = '0;
      v.d0 = vd; v.d1 = rd; v.d2 = sw; v.cfg_a = ca; v.cfg_b = cb; v.late = lt;
      v.e_cpu = ec; v.e_resp = er; v.e_tmo = et; v.e_rdata = edat; v.e_rresp = eresp;
      return v;
   endfunction

   // Write timing: both halves land by the later delay, strobe and response next cycle.
   function automatic vec_t model_wr(input vec_t v);
      vec_t r = v;
      r.e_cpu  = ((v.d0 > v.d1) ? v.d0 : v.d1) + 1;
      r.e_resp = r.e_cpu;
      return r;
   endfunction

   // Read timing: AR accepted at cycle 0, waiting from cycle 1 with elapsed
   // wait count t-1; first data pulse or count==cfg (cfg!=0) resolves it.
   function automatic vec_t model_rd(input vec_t v);
      vec_t r = v;
      logic [15:0] cfg;
      r.e_cpu = 1; r.e_tmo = -1; r.e_resp = -1; r.e_rdata = '0; r.e_rresp = 2'b00;
      for (int t = 1; t < BOUND; t++) begin
         cfg = (t >= v.d2) ? v.cfg_b : v.cfg_a;
         if (t == v.d0 || t == v.late) begin
            r.e_resp  = t + 1;
            r.e_rdata = (t == v.late) ? ~v.data : v.data;
            r.e_rresp = 2'b00;
            break;
         end
         if (cfg != 16'd0 && (t - 1) == int'(cfg)) begin
            r.e_tmo   = t;
            r.e_resp  = t + 1;
            r.e_rdata = 32'hDEADBEEF;
            r.e_rresp = 2'b10;
            break;
         end
      end
      return r;
   endfunction

   task automatic run_wr(input vec_t v, input string tag);
      int n_wr = 0, c_wr = -1, n_b = 0, c_b = -1;
      logic aw_done = 1'b0, w_done = 1'b0, b_done = 1'b0, ar_bad = 1'b0;
      logic [31:0] o_addr = '0, o_data = '0;
      logic [3:0]  o_strb = '0;
      logic [1:0]  o_bresp = 2'b11;
      for (int t = 0; t < BOUND && !b_done; t++) begin
         if (cpu_wr) begin
            n_wr++;
            if (c_wr < 0) begin
               c_wr = t; o_addr = cpu_wr_addr; o_data = cpu_data_out; o_strb = cpu_wr_strb;
            end
         end
         if (bvalid) begin
            n_b++;
            if (c_b < 0) begin c_b = t; o_bresp = bresp; end
         end
         awvalid = !aw_done && (t >= v.d0); awaddr = v.addr;
         wvalid  = !w_done && (t >= v.d1);  wdata = v.data; wstrb = v.strb;
         bready  = bvalid && (t >= c_b + v.d2);
         #1;
         if ((awvalid || wvalid || aw_done || w_done) && arready) ar_bad = 1'b1;
         if (awvalid && awready) aw_done = 1'b1;
         if (wvalid && wready) w_done = 1'b1;
         if (bvalid && bready) b_done = 1'b1;
         tick();
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      chk({tag, " completed"}, 160'(b_done), 160'(1));
      chk({tag, " cpu_wr count"}, 160'(n_wr), 160'(1));
      chk({tag, " cpu_wr cycle"}, 160'(c_wr), 160'(v.e_cpu));
      chk({tag, " wr addr/data/strb"}, {o_addr, o_data, o_strb}, {v.addr, v.data, v.strb});
      chk({tag, " bvalid cycle"}, 160'(c_b), 160'(v.e_resp));
      chk({tag, " bvalid length"}, 160'(n_b), 160'(v.d2 + 1));
      chk({tag, " bresp"}, 160'(o_bresp), 160'(0));
      chk({tag, " arready during write"}, 160'(ar_bad), 160'(0));
      chk({tag, " wr addr held"}, 160'(cpu_wr_addr), 160'(v.addr));
   endtask

   task automatic run_rd(input vec_t v, input string tag);
      int n_rd = 0, c_rd = -1, n_r = 0, c_r = -1, n_t = 0, c_t = -1;
      logic ar_done = 1'b0, r_done = 1'b0, unstable = 1'b0;
      logic [31:0] o_rd_addr = '0, o_rdata = '0;
      logic [1:0]  o_rresp = 2'b11;
      for (int t = 0; t < BOUND; t++) begin
         if (cpu_rd) begin
            n_rd++;
            if (c_rd < 0) begin c_rd = t; o_rd_addr = cpu_rd_addr; end
         end
         if (rvalid) begin
            n_r++;
            if (c_r < 0) begin c_r = t; o_rdata = rdata; o_rresp = rresp; end
            else if (rdata !== o_rdata || rresp !== o_rresp) unstable = 1'b1;
         end
         arvalid = !ar_done; araddr = v.addr;
         cpu_data_in_vld = (t == v.d0) || (t == v.late);
         cpu_data_in     = (t == v.late) ? ~v.data : v.data;
         rd_tmout_cfg    = (t >= v.d2) ? v.cfg_b : v.cfg_a;
         rready = rvalid && (t >= c_r + v.d1);
         #1;
         if (arvalid && arready) ar_done = 1'b1;
         if (rd_tmout_err) begin
            n_t++;
            if (c_t < 0) c_t = t;
         end
         if (rvalid && rready) r_done = 1'b1;
         tick();
         if (r_done && t >= v.late) break;
      end
      arvalid = 1'b0; cpu_data_in_vld = 1'b0; rready = 1'b0; rd_tmout_cfg = '0;
      chk({tag, " completed"}, 160'(r_done), 160'(1));
      chk({tag, " cpu_rd count"}, 160'(n_rd), 160'(1));
      chk({tag, " cpu_rd cycle/addr"}, {128'(c_rd), o_rd_addr}, {128'(v.e_cpu), v.addr});
      chk({tag, " tmout_err count"}, 160'(n_t), 160'((v.e_tmo < 0) ? 0 : 1));
      chk({tag, " tmout_err cycle"}, 160'(c_t), 160'(v.e_tmo));
      chk({tag, " rvalid cycle"}, 160'(c_r), 160'(v.e_resp));
      chk({tag, " rvalid length"}, 160'(n_r), 160'(v.d1 + 1));
      chk({tag, " rdata/rresp"}, {o_rdata, o_rresp}, {v.e_rdata, v.e_rresp});
      chk({tag, " r stable"}, 160'(unstable), 160'(0));
   endtask

   task automatic chk_all_zero(input string tag);
      logic [143:0] z;
      z = {awready, wready, arready, bvalid, bresp, rvalid, rdata, rresp, cpu_wr, cpu_wr_addr,
           cpu_wr_strb, cpu_data_out, cpu_rd, cpu_rd_addr, rd_tmout_err};
      chk({tag, " outputs zero"}, 160'(z), 160'(0));
   endtask

   // Release reset and confirm no ready and no stray activity afterwards.
   task automatic release_reset(input string tag);
      logic stray = 1'b0;
      areset = 1'b0;
      tick();
      chk({tag, " no ready first cycle"}, 160'({awready, wready, arready}), 160'(0));
      for (int i = 0; i < 5; i++) begin
         if (rvalid || bvalid || cpu_rd || cpu_wr || rd_tmout_err) stray = 1'b1;
         tick();
      end
      cpu_data_in_vld = 1'b0; rready = 1'b0; bready = 1'b0;
      chk({tag, " no activity after release"}, 160'(stray), 160'(0));
   endtask

   initial begin
      vec_t v;
      string tag;

      #2 areset = 1'b1;
      tick(); tick();
      chk_all_zero("reset");
      release_reset("reset");

      // Directed table with hand-derived expectations.
      tbl[0] = mk_wr(32'h10, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 1, 1);
      tbl[1] = mk_wr(32'h44, 32'h0BADF00D, 4'h3, 3, 0, 5, 4, 4);
      tbl[2] = mk_wr(32'h80, 32'h11223344, 4'hC, 0, 2, 1, 3, 3);
      tbl[3] = mk_rd(32'h20, 32'h12345678, 4, -1, 0, 16'd0, 16'd0, 0, 1, 5, -1, 32'h12345678, 2'b00);
      tbl[4] = mk_rd(32'h24, 32'h00000055, -1, 8, 0, 16'd4, 16'd4, 0, 1, 6, 5, 32'hDEADBEEF, 2'b10);
      tbl[5] = mk_rd(32'h28, 32'hCAFEF00D, 4, -1, 0, 16'd3, 16'd3, 0, 1, 5, -1, 32'hCAFEF00D, 2'b00);
      tbl[6] = mk_rd(32'h2C, 32'h00000001, -1, -1, 0, 16'd0, 16'd7, 6, 1, 9, 8, 32'hDEADBEEF, 2'b10);
      tbl[7] = mk_rd(32'h30, 32'h00000077, -1, 4, 3, 16'd1, 16'd1, 0, 1, 3, 2, 32'hDEADBEEF, 2'b10);
      for (int i = 0; i < 8; i++) begin
         tag = $sformatf("vec%0d", i);
         if (tbl[i].is_rd) run_rd(tbl[i], tag);
         else run_wr(tbl[i], tag);
      end

      // Simultaneous AW+W+AR: write first, read once no write valid remains.
      awvalid = 1'b1; awaddr = 32'h50; wvalid = 1'b1; wdata = 32'h600DCAFE; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'h60; bready = 1'b1; rready = 1'b1;
      #1 chk("simul arready c0", 160'(arready), 160'(0));
      tick();
      chk("simul cpu_wr/bvalid c1", 160'({cpu_wr, bvalid, cpu_rd}), 160'(3'b110));
      chk("simul wr addr c1", 160'(cpu_wr_addr), 160'(32'h50));
      awvalid = 1'b0; wvalid = 1'b0;
      #1 chk("simul arready c1", 160'(arready), 160'(0));
      tick();
      #1 chk("simul arready c2", 160'(arready), 160'(1));
      tick();
      chk("simul cpu_rd c3", {128'(cpu_rd), cpu_rd_addr}, {128'(1), 32'h60});
      arvalid = 1'b0;
      tick();
      cpu_data_in_vld = 1'b1; cpu_data_in = 32'h0F0F0F0F;
      tick();
      cpu_data_in_vld = 1'b0;
      chk("simul rvalid c5", {128'(rvalid), rdata}, {128'(1), 32'h0F0F0F0F});
      tick();
      rready = 1'b0; bready = 1'b0;
      tick();

      // Reset while waiting for local read data.
      arvalid = 1'b1; araddr = 32'h70;
      tick();
      arvalid = 1'b0;
      tick();
      #2 areset = 1'b1;
      #1 chk_all_zero("mid-read reset");
      tick(); tick();
      cpu_data_in_vld = 1'b1; cpu_data_in = 32'h99999999; rready = 1'b1; bready = 1'b1;
      release_reset("mid-read reset");
      tick();
      v = model_rd(mk_rd(32'h74, 32'h13572468, 3, -1, 1, 16'd0, 16'd0, 0, 0, 0, 0, '0, 2'b00));
      run_rd(v, "post-reset read");

      // Random transactions checked against the timing model.
      for (int i = 0; i < 40; i++) begin
         tag = $sformatf("rnd%0d", i);
         if ($urandom_range(0, 1) == 0) begin
            v = mk_wr($urandom, $urandom, 4'($urandom_range(0, 15)),
                      int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 3)), 0, 0);
            run_wr(model_wr(v), tag);
         end else begin
            v = mk_rd($urandom, $urandom, int'($urandom_range(0, 10)), -1,
                      int'($urandom_range(0, 3)), 16'd0, 16'd0, 0, 0, 0, 0, '0, 2'b00);
            v.cfg_a = 16'($urandom_range(0, 6));
            v.cfg_b = v.cfg_a;
            if (v.cfg_a == 16'd0 && v.d0 == 0) v.d0 = 1;
            if ($urandom_range(0, 3) == 0) v.late = v.d0 + int'($urandom_range(1, 4));
            run_rd(model_rd(v), tag);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
